nfc_command_queue_adapter: RTL

NFC_COMMAND_QUEUE_ADAPTER -- requirements
Module: nfc_command_queue_adapter

---
 rtl/nfc_adapter_pkg.sv | 28 ++
 rtl/nfc_cmd_fifo.sv | 71 +++++++
 rtl/nfc_command_queue_adapter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nfc_adapter_pkg.sv
// Shared constants for the NFC command queue adapter: command word field
// positions, dispatch FSM encoding and status word bit positions.
package nfc_adapter_pkg;

  // Command word fields
  localparam int OpcodeLsb   = 0;
  localparam int OpcodeWidth = 6;
  localparam int TargetLsb   = 16;
  localparam int TargetWidth = 5;
  localparam int FlushBit    = 31;

  // Queue occupancy counter width (holds 0..8)
  localparam int CountWidth  = 4;

  // Dispatch FSM encoding
  localparam logic [1:0] StateIdle   = 2'd0;
  localparam logic [1:0] StateWaitRb = 2'd1;
  localparam logic [1:0] StateIssue  = 2'd2;

  // Status word bit positions
  localparam int StatReadyBit = 0;
  localparam int StatEmptyBit = 1;
  localparam int StatFullBit  = 2;
  localparam int StatFailBit  = 3;
  localparam int StatCountLsb = 4;
  localparam int StatDevLsb   = 8;

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Purpose: synchronous command FIFO with occupancy count and clear, no fall-through.
// Latency: a pushed entry becomes visible at head_dat_o the edge after the push.
// Backpressure: push ignored while full, pop ignored while empty; clear wins over both.
module nfc_cmd_fifo
  import nfc_adapter_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 4   // power of two so pointers wrap naturally
) (
  input  logic                  iSystemClock,
  input  logic                  iReset,
  input  logic                  push_i,
  input  logic [Width-1:0]      push_dat_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [Width-1:0]      head_dat_o,
  output logic [CountWidth-1:0] count_o,
  output logic [CountWidth-1:0] count_nxt_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != CountWidth'(Depth)) && !clear_i;
  assign do_pop  = pop_i  && (count_q != '0) && !clear_i;

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CountWidth-1){1'b0}}, do_push}
                        - {{(CountWidth-1){1'b0}}, do_pop};
    end
  end

  // Pointer and count registers
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents only meaningful while counted, so no reset
  always_ff @(posedge iSystemClock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/nfc_command_queue_adapter.sv
// Purpose: queues register-written NAND commands and dispatches them in order once the target way is ready.
// Latency: command sampled at edge N+1 after being driven, oCMDValid rises at edge N+2 when way and queue allow.
// Backpressure: oCMDValid/fields held until iCMDReady; pushes rejected (sticky oCommandFail) when full or bad target.
module nfc_command_queue_adapter
  import nfc_adapter_pkg::*;
#(
  parameter int NumberOfWays = 2,
  parameter int QueueDepth   = 4,
  parameter int AddressWidth = 32,
  parameter int LengthWidth  = 16
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iAxilValid,
  input  logic [31:0]             iCommand,
  input  logic                    iCommandValid,
  input  logic [AddressWidth-1:0] iAddress,
  input  logic [LengthWidth-1:0]  iLength,
  output logic                    oCommandFail,
  output logic [31:0]             oNFCStatus,
  output logic [31:0]             oNandRBStatus,
  output logic [5:0]              oOpcode,
  output logic [4:0]              oTargetID,
  output logic [4:0]              oSourceID,
  output logic [AddressWidth-1:0] oAddress,
  output logic [LengthWidth-1:0]  oLength,
  output logic                    oCMDValid,
  input  logic                    iCMDReady,
  input  logic [23:0]             iStatus,
  input  logic                    iStatusValid,
  input  logic [NumberOfWays-1:0] iReadyBusy
);

  localparam int EntryWidth = OpcodeWidth + TargetWidth + AddressWidth + LengthWidth;

  logic                    cmd_write, flush_req, push_req, push_acc, push_rej, tgt_ok;
  logic [OpcodeWidth-1:0]  cmd_opcode;
  logic [TargetWidth-1:0]  cmd_target;
  logic [EntryWidth-1:0]   push_entry, head_entry;
  logic [CountWidth-1:0]   count, count_nxt;
  logic                    q_full, q_empty, head_ready, handshake, fifo_pop, load;
  logic [31:0]             rb_ext;
  logic [OpcodeWidth-1:0]  head_opcode;
  logic [TargetWidth-1:0]  head_target;
  logic [AddressWidth-1:0] head_address;
  logic [LengthWidth-1:0]  head_length;

  logic [1:0]              state_q, state_d;
  logic                    fail_q, fail_d;
  logic                    issue_flushed_q, issue_flushed_d;
  logic [OpcodeWidth-1:0]  opcode_q, opcode_d;
  logic [TargetWidth-1:0]  target_q, target_d;
  logic [AddressWidth-1:0] address_q, address_d;
  logic [LengthWidth-1:0]  length_q, length_d;
  logic [31:0]             status_q, status_d;
  logic [31:0]             rb_q;

  // Reserved command bits carry no meaning here
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{iCommand[15:6], iCommand[30:21]};

  assign cmd_opcode = iCommand[OpcodeLsb +: OpcodeWidth];
  assign cmd_target = iCommand[TargetLsb +: TargetWidth];
  assign cmd_write  = iAxilValid && iCommandValid;
  assign flush_req  = cmd_write && iCommand[FlushBit];
  assign push_req   = cmd_write && !iCommand[FlushBit];
  assign tgt_ok     = ({27'd0, cmd_target} < 32'(NumberOfWays));

  // Full is judged on the registered count, so a same-cycle pop cannot make room
  assign q_full   = (count == CountWidth'(QueueDepth));
  assign q_empty  = (count == '0);
  assign push_acc = push_req && !q_full && tgt_ok;
  assign push_rej = push_req && !push_acc;

  assign push_entry   = {cmd_opcode, cmd_target, iAddress, iLength};
  assign head_opcode  = head_entry[EntryWidth-1 -: OpcodeWidth];
  assign head_target  = head_entry[AddressWidth+LengthWidth +: TargetWidth];
  assign head_address = head_entry[LengthWidth +: AddressWidth];
  assign head_length  = head_entry[LengthWidth-1:0];

  // Widen ready/busy so any 5-bit target indexes safely
  always_comb begin
    rb_ext = '0;
    rb_ext[NumberOfWays-1:0] = iReadyBusy;
  end

  assign head_ready = rb_ext[head_target];
  assign handshake  = (state_q == StateIssue) && iCMDReady;
  // An entry flushed while being presented is already gone from the queue
  assign fifo_pop   = handshake && !issue_flushed_q;

  nfc_cmd_fifo #(
    .Width (EntryWidth),
    .Depth (QueueDepth)
  ) u_fifo (
    .iSystemClock (iSystemClock),
    .iReset       (iReset),
    .push_i       (push_acc),
    .push_dat_i   (push_entry),
    .pop_i        (fifo_pop),
    .clear_i      (flush_req),
    .head_dat_o   (head_entry),
    .count_o      (count),
    .count_nxt_o  (count_nxt)
  );

  // Dispatch FSM: a flush suppresses any new issue in the same cycle
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StateIdle: begin
        if (!q_empty && !flush_req) begin
          if (head_ready) begin
            state_d = StateIssue;
            load    = 1'b1;
          end else begin
            state_d = StateWaitRb;
          end
        end
      end
      StateWaitRb: begin
        if (flush_req) begin
          state_d = StateIdle;
        end else if (head_ready) begin
          state_d = StateIssue;
          load    = 1'b1;
        end
      end
      StateIssue: begin
        if (iCMDReady) state_d = StateIdle;
      end
      default: state_d = StateIdle;
    endcase
  end

  // Output fields, fail flag, flushed-while-issuing marker and status word
  always_comb begin
    opcode_d  = load ? head_opcode  : opcode_q;
    target_d  = load ? head_target  : target_q;
    address_d = load ? head_address : address_q;
    length_d  = load ? head_length  : length_q;

    fail_d = fail_q;
    if (push_rej)      fail_d = 1'b1;
    else if (push_acc) fail_d = 1'b0;

    issue_flushed_d = issue_flushed_q;
    if (load || handshake)                       issue_flushed_d = 1'b0;
    else if (flush_req && state_q == StateIssue) issue_flushed_d = 1'b1;

    status_d = status_q;
    if (iStatusValid) status_d[31:StatDevLsb] = iStatus;
    status_d[StatCountLsb +: CountWidth] = count_nxt;
    status_d[StatFailBit]  = fail_d;
    status_d[StatFullBit]  = (count_nxt == CountWidth'(QueueDepth));
    status_d[StatEmptyBit] = (count_nxt == '0);
    status_d[StatReadyBit] = iCMDReady;
  end

  // State registers with synchronous reset
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q         <= StateIdle;
      fail_q          <= 1'b0;
      issue_flushed_q <= 1'b0;
      opcode_q        <= '0;
      target_q        <= '0;
      address_q       <= '0;
      length_q        <= '0;
      status_q        <= 32'd1 << StatEmptyBit;
      rb_q            <= '0;
    end else begin
      state_q         <= state_d;
      fail_q          <= fail_d;
      issue_flushed_q <= issue_flushed_d;
      opcode_q        <= opcode_d;
      target_q        <= target_d;
      address_q       <= address_d;
      length_q        <= length_d;
      status_q        <= status_d;
      rb_q            <= rb_ext;
    end
  end

  assign oCMDValid     = (state_q == StateIssue);
  assign oCommandFail  = fail_q;
  assign oOpcode       = opcode_q;
  assign oTargetID     = target_q;
  assign oSourceID     = 5'd0;
  assign oAddress      = address_q;
  assign oLength       = length_q;
  assign oNFCStatus    = status_q;
  assign oNandRBStatus = rb_q;

endmodule
